// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the five-stage MIPS core.
// Holds the PC, drives the instruction memory address and loads the IF/ID
// pipeline register. Redirects from the ID stage (jr, jal, taken beq) take
// effect with one branch delay slot and no squash.
// Optional feature: define FETCH_ALIGN_CHECK_EN to halt on a misaligned PC.
module fetch_unit #(
    parameter logic [31:0] PC_RESET       = 32'h0000_3000,
    parameter int          IM_DEPTH_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        id_isJr,
    input  logic        id_isJal,
    input  logic        id_isBranch,
    input  logic        id_br_taken,
    input  logic [15:0] id_imm,
    input  logic [25:0] id_ins_index,
    input  logic [31:0] id_rs_val,
    output logic [31:0] im_addr,
    input  logic [31:0] im_rdata,
    output logic [31:0] ifid_ins,
    output logic [31:0] ifid_pc,
    output logic        ifid_valid,
    output logic        halted,
    output logic [1:0]  halt_cause
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetchState_t;

    // One past the last legal fetch address, kept 33 bits wide so the
    // upper bound never wraps.
    localparam logic [32:0] IM_END = {1'b0, PC_RESET} + 33'(IM_DEPTH_WORDS) * 33'd4;

    fetchState_t r_state;
    fetchState_t w_nextState;
    logic [31:0] r_pc;
    logic [31:0] r_ifidIns;
    logic [31:0] r_ifidPc;
    logic        r_ifidValid;
    logic [1:0]  r_haltCause;

    logic [31:0] w_nextPc;
    logic [31:0] w_nextIns;
    logic [31:0] w_nextIfidPc;
    logic        w_nextValid;
    logic [1:0]  w_nextCause;

    logic [31:0] w_ifidPcPlus4;
    logic [31:0] w_brOffset;
    logic [31:0] w_targetPc;
    logic        w_outOfRange;
    logic        w_misaligned;
    logic        w_haltFetch;

    assign w_ifidPcPlus4 = r_ifidPc + 32'd4;
    assign w_brOffset    = {{14{id_imm[15]}}, id_imm, 2'b00};
    assign w_outOfRange  = ({1'b0, r_pc} < {1'b0, PC_RESET}) || ({1'b0, r_pc} >= IM_END);

`ifdef FETCH_ALIGN_CHECK_EN
    assign w_misaligned = (r_pc[1:0] != 2'b00);
`else
    assign w_misaligned = 1'b0;
`endif

    assign w_haltFetch = w_outOfRange | w_misaligned;

    // Pick the next PC; ID-stage redirects only count for a real IF/ID instruction.
    always_comb begin
        w_targetPc = r_pc + 32'd4;
        if (r_ifidValid) begin
            if (id_isJr) begin
                w_targetPc = id_rs_val;
            end else if (id_isJal) begin
                w_targetPc = {w_ifidPcPlus4[31:28], id_ins_index, 2'b00};
            end else if (id_isBranch && id_br_taken) begin
                w_targetPc = w_ifidPcPlus4 + w_brOffset;
            end
        end
    end

    // Next-state and next-register values for the RUN/HALT controller.
    always_comb begin
        w_nextState  = r_state;
        w_nextPc     = r_pc;
        w_nextIns    = r_ifidIns;
        w_nextIfidPc = r_ifidPc;
        w_nextValid  = r_ifidValid;
        w_nextCause  = r_haltCause;
        case (r_state)
            RUN: begin
                if (!stall) begin
                    if (w_haltFetch) begin
                        w_nextIns   = 32'd0;
                        w_nextValid = 1'b0;
                        w_nextCause = {w_misaligned, w_outOfRange};
                        w_nextState = HALT;
                    end else begin
                        w_nextIns    = im_rdata;
                        w_nextIfidPc = r_pc;
                        w_nextValid  = 1'b1;
                        w_nextPc     = w_targetPc;
                    end
                end
            end
            HALT: begin
                w_nextIns   = 32'd0;
                w_nextValid = 1'b0;
            end
            default: begin
                w_nextState = RUN;
            end
        endcase
    end

    // State and pipeline registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= RUN;
            r_pc        <= PC_RESET;
            r_ifidIns   <= 32'd0;
            r_ifidPc    <= 32'd0;
            r_ifidValid <= 1'b0;
            r_haltCause <= 2'b00;
        end else begin
            r_state     <= w_nextState;
            r_pc        <= w_nextPc;
            r_ifidIns   <= w_nextIns;
            r_ifidPc    <= w_nextIfidPc;
            r_ifidValid <= w_nextValid;
            r_haltCause <= w_nextCause;
        end
    end

    assign im_addr    = r_pc;
    assign ifid_ins   = r_ifidIns;
    assign ifid_pc    = r_ifidPc;
    assign ifid_valid = r_ifidValid;
    assign halted     = (r_state == HALT);
    assign halt_cause = r_haltCause;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized scoreboard bench for fetch_unit.
// A stimulus process drives one cycle at a time and pushes the expected
// post-edge view of the stage; a monitor pops and compares after each edge.
module tb_fetch_unit;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam int          IM_DEPTH = 4096;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic        id_isJr;
    logic        id_isJal;
    logic        id_isBranch;
    logic        id_br_taken;
    logic [15:0] id_imm;
    logic [25:0] id_ins_index;
    logic [31:0] id_rs_val;
    logic [31:0] im_addr;
    logic [31:0] im_rdata;
    logic [31:0] ifid_ins;
    logic [31:0] ifid_pc;
    logic        ifid_valid;
    logic        halted;
    logic [1:0]  halt_cause;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] ifPc;
        logic        valid;
        logic        halted;
        logic [1:0]  cause;
    } expect_t;

    expect_t sbQ[$];

    int total = 0;
    int bad   = 0;

    // Reference model state: what the stage should hold after the last edge.
    logic [31:0] mPc;
    logic [31:0] mIns;
    logic [31:0] mIfPc;
    logic        mValid;
    logic        mHalted;
    logic [1:0]  mCause;

    fetch_unit #(
        .PC_RESET(PC_RESET),
        .IM_DEPTH_WORDS(IM_DEPTH)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .stall(stall),
        .id_isJr(id_isJr),
        .id_isJal(id_isJal),
        .id_isBranch(id_isBranch),
        .id_br_taken(id_br_taken),
        .id_imm(id_imm),
        .id_ins_index(id_ins_index),
        .id_rs_val(id_rs_val),
        .im_addr(im_addr),
        .im_rdata(im_rdata),
        .ifid_ins(ifid_ins),
        .ifid_pc(ifid_pc),
        .ifid_valid(ifid_valid),
        .halted(halted),
        .halt_cause(halt_cause)
    );

    // Instruction memory contents are a fixed scramble of the address.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] ^ a[15:0] ^ 16'h5A17};
    endfunction

    assign im_rdata = memWord(im_addr);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    task automatic checkOutput(input expect_t e);
        checkField("im_addr", im_addr, e.pc);
        checkField("ifid_ins", ifid_ins, e.ins);
        checkField("ifid_pc", ifid_pc, e.ifPc);
        checkField("ifid_valid", 32'(ifid_valid), 32'(e.valid));
        checkField("halted", 32'(halted), 32'(e.halted));
        checkField("halt_cause", 32'(halt_cause), 32'(e.cause));
    endtask

    // Monitor: after every rising edge, compare against the oldest expectation.
    initial begin
        expect_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbQ.size() > 0) begin
                e = sbQ.pop_front();
                checkOutput(e);
            end
        end
    end

    // Drive one cycle of inputs, advance the model by the fetch rules, push the result.
    task automatic applyStimulus(input logic rst_n, input logic stl, input logic jr,
                                 input logic jal, input logic br, input logic tk,
                                 input logic [15:0] imm, input logic [25:0] idx,
                                 input logic [31:0] rs);
        logic [63:0] p;
        logic        oor;
        logic        mis;
        logic [31:0] tgt;
        logic [31:0] link;
        expect_t     e;
        @(negedge clk);
        reset_n      = rst_n;
        stall        = stl;
        id_isJr      = jr;
        id_isJal     = jal;
        id_isBranch  = br;
        id_br_taken  = tk;
        id_imm       = imm;
        id_ins_index = idx;
        id_rs_val    = rs;

        if (!rst_n) begin
            mPc = PC_RESET; mIns = 0; mIfPc = 0; mValid = 0; mHalted = 0; mCause = 0;
        end else if (mHalted) begin
            mIns = 0; mValid = 0;
        end else if (!stl) begin
            p   = 64'(mPc);
            oor = (p < 64'(PC_RESET)) || (p >= 64'(PC_RESET) + 64'(4 * IM_DEPTH));
`ifdef FETCH_ALIGN_CHECK_EN
            mis = (mPc % 4) != 0;
`else
            mis = 1'b0;
`endif
            if (oor || mis) begin
                mIns = 0; mValid = 0; mCause = {mis, oor}; mHalted = 1;
            end else begin
                link = mIfPc + 4;
                tgt  = mPc + 4;
                if (mValid && jr)
                    tgt = rs;
                else if (mValid && jal)
                    tgt = (link & 32'hF000_0000) | (32'(idx) * 4);
                else if (mValid && br && tk)
                    tgt = link + 32'($signed(imm) * 4);
                mIns   = memWord(mPc);
                mIfPc  = mPc;
                mValid = 1;
                mPc    = tgt;
            end
        end
        e.pc = mPc; e.ins = mIns; e.ifPc = mIfPc;
        e.valid = mValid; e.halted = mHalted; e.cause = mCause;
        sbQ.push_back(e);
    endtask

    initial begin
        int          haltCycles;
        int          r;
        int          sel;
        logic        rst_n;
        logic        stl;
        logic        tk;
        logic [15:0] imm;
        logic [25:0] idx;
        logic [31:0] rs;

        reset_n = 1'b0; stall = 1'b0; id_isJr = 1'b0; id_isJal = 1'b0;
        id_isBranch = 1'b0; id_br_taken = 1'b0; id_imm = '0; id_ins_index = '0; id_rs_val = '0;
        mPc = '0; mIns = '0; mIfPc = '0; mValid = 1'b0; mHalted = 1'b0; mCause = '0;

        $display("[TB] reset and straight-line fetch");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);

        $display("[TB] randomized redirects, stalls, halts and resets");
        haltCycles = 0;
        for (int i = 0; i < 3000; i++) begin
            rst_n = 1'b1;
            if (mHalted && haltCycles >= 4)
                rst_n = 1'b0;
            else if ($urandom_range(0, 99) == 0)
                rst_n = 1'b0;
            stl = ($urandom_range(0, 3) == 0);
            r   = $urandom_range(0, 99);
            tk  = 1'($urandom_range(0, 1));
            imm = 16'(int'($urandom_range(0, 64)) - 32);
            idx = 26'(32'hC00 + $urandom_range(0, 4095));
            if ($urandom_range(0, 9) == 0)
                idx = 26'($urandom);
            sel = $urandom_range(0, 19);
            case (sel)
                0:       rs = 32'h0000_7000;
                1:       rs = 32'h0000_2FFC;
                2:       rs = 32'hFFFF_FFFC;
                3:       rs = 32'h0000_3002 + 32'(4 * $urandom_range(0, 15));
                default: rs = PC_RESET + 32'(4 * $urandom_range(0, 4095));
            endcase
            applyStimulus(rst_n, stl, r < 8, r >= 8 && r < 16, r >= 16 && r < 40, tk, imm, idx, rs);
            if (mHalted)
                haltCycles++;
            else
                haltCycles = 0;
        end

        @(posedge clk);
        #2;
        total++;
        if (sbQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_drain: got %0d left want 0", sbQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
